dcache_miss_controller: RTL and testbench

//  Sequences the data-cache for LW/LB/SW/SB. Owns the tag/valid/dirty arrays of a direct-mapped,

---
 rtl/dcache_miss_controller_if.sv | 38 +++
 rtl/dcache_miss_controller.sv | 160 ++++++++++++++++
 tb/tb_dcache_miss_controller.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/dcache_miss_controller_if.sv
// Bundle of CPU request, data-array write port and main-memory beat handshake
// signals used by dcache_miss_controller.
interface dcache_miss_controller_if #(
  parameter int unsigned NUM_LINES   = 256,
  parameter int unsigned BLOCK_WORDS = 4
);
  localparam int unsigned IDX_W = $clog2(NUM_LINES);
  localparam int unsigned OFF_W = $clog2(BLOCK_WORDS);
  localparam int unsigned DA_W  = IDX_W + OFF_W;

  logic            req_valid;
  logic            req_write;
  logic [31:0]     req_addr;
  logic            hit;
  logic            da_we;
  logic            da_src;
  logic [DA_W-1:0] da_index;
  logic            mem_req;
  logic            mem_we;
  logic [31:0]     mem_addr;
  logic            mem_ack;
  logic [31:0]     hit_count;
  logic [31:0]     miss_count;

  // Environment side: CPU pipeline and main memory.
  modport master (
    output req_valid, req_write, req_addr, mem_ack,
    input  hit, da_we, da_src, da_index, mem_req, mem_we, mem_addr,
           hit_count, miss_count
  );

  // Cache controller side.
  modport slave (
    input  req_valid, req_write, req_addr, mem_ack,
    output hit, da_we, da_src, da_index, mem_req, mem_we, mem_addr,
           hit_count, miss_count
  );
endinterface

// File: rtl/dcache_miss_controller.sv
// Miss sequencer and tag/valid/dirty store for a direct-mapped, write-back,
// write-allocate data cache; hit is combinational so the core can stall on a miss.
module dcache_miss_controller #(
  parameter int unsigned NUM_LINES   = 256,
  parameter int unsigned BLOCK_WORDS = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  dcache_miss_controller_if.slave bus
);
  localparam int unsigned IDX_W = $clog2(NUM_LINES);
  localparam int unsigned OFF_W = $clog2(BLOCK_WORDS);
  localparam int unsigned DA_W  = IDX_W + OFF_W;
  localparam int unsigned TAG_W = 30 - IDX_W - OFF_W;

  typedef enum logic [1:0] {
    S_COMPARE   = 2'd0,
    S_WRITEBACK = 2'd1,
    S_REFILL    = 2'd2
  } state_t;

  state_t             r_state;
  logic [IDX_W-1:0]   r_idx;
  logic [TAG_W-1:0]   r_req_tag;
  logic [TAG_W-1:0]   r_wb_tag;
  logic [OFF_W-1:0]   r_beat;
  logic [NUM_LINES-1:0] r_valid;
  logic [NUM_LINES-1:0] r_dirty;
  logic [TAG_W-1:0]   r_tag_arr [NUM_LINES];
  logic [31:0]        r_hit_count;
  logic [31:0]        r_miss_count;

  logic [TAG_W-1:0]   w_tag;
  logic [IDX_W-1:0]   w_idx;
  logic [OFF_W-1:0]   w_word;
  logic               w_hit;
  logic               w_miss;
  logic               w_last;
  logic               w_fill_done;
  logic               w_da_we;
  logic               w_da_src;
  logic [DA_W-1:0]    w_da_index;
  logic               w_mem_req;
  logic               w_mem_we;
  logic [31:0]        w_mem_addr;

  assign w_tag  = bus.req_addr[31 -: TAG_W];
  assign w_idx  = bus.req_addr[OFF_W+2 +: IDX_W];
  assign w_word = bus.req_addr[2 +: OFF_W];

  assign w_hit  = (r_state == S_COMPARE) && bus.req_valid && r_valid[w_idx] &&
                  (r_tag_arr[w_idx] == w_tag);
  assign w_miss = (r_state == S_COMPARE) && bus.req_valid && !w_hit;
  assign w_last = (r_beat == OFF_W'(BLOCK_WORDS - 1));
  assign w_fill_done = (r_state == S_REFILL) && bus.mem_ack && w_last;

  // Output decode; memory address is built from latched miss state so it stays stable while stalled.
  always_comb begin
    w_da_we    = 1'b0;
    w_da_src   = 1'b0;
    w_da_index = '0;
    w_mem_req  = 1'b0;
    w_mem_we   = 1'b0;
    w_mem_addr = '0;
    case (r_state)
      S_COMPARE: begin
        if (w_hit && bus.req_write) begin
          w_da_we    = 1'b1;
          w_da_index = {w_idx, w_word};
        end
      end
      S_WRITEBACK: begin
        w_mem_req  = 1'b1;
        w_mem_we   = 1'b1;
        w_mem_addr = {r_wb_tag, r_idx, r_beat, 2'b00};
      end
      S_REFILL: begin
        w_mem_req  = 1'b1;
        w_mem_addr = {r_req_tag, r_idx, r_beat, 2'b00};
        if (bus.mem_ack) begin
          w_da_we    = 1'b1;
          w_da_src   = 1'b1;
          w_da_index = {r_idx, r_beat};
        end
      end
      default: ;
    endcase
  end

  assign bus.hit        = w_hit;
  assign bus.da_we      = w_da_we;
  assign bus.da_src     = w_da_src;
  assign bus.da_index   = w_da_index;
  assign bus.mem_req    = w_mem_req;
  assign bus.mem_we     = w_mem_we;
  assign bus.mem_addr   = w_mem_addr;
  assign bus.hit_count  = r_hit_count;
  assign bus.miss_count = r_miss_count;

  // Sequencer, valid/dirty bits and statistics; reset empties the cache.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_COMPARE;
      r_idx        <= '0;
      r_req_tag    <= '0;
      r_wb_tag     <= '0;
      r_beat       <= '0;
      r_valid      <= '0;
      r_dirty      <= '0;
      r_hit_count  <= '0;
      r_miss_count <= '0;
    end else begin
      if (w_hit && (r_hit_count != 32'hFFFF_FFFF)) begin
        r_hit_count <= r_hit_count + 32'd1;
      end
      case (r_state)
        S_COMPARE: begin
          if (w_hit && bus.req_write) begin
            r_dirty[w_idx] <= 1'b1;
          end else if (w_miss) begin
            if (r_miss_count != 32'hFFFF_FFFF) begin
              r_miss_count <= r_miss_count + 32'd1;
            end
            r_idx     <= w_idx;
            r_req_tag <= w_tag;
            r_wb_tag  <= r_tag_arr[w_idx];
            r_beat    <= '0;
            r_state   <= (r_valid[w_idx] && r_dirty[w_idx]) ? S_WRITEBACK : S_REFILL;
          end
        end
        S_WRITEBACK: begin
          if (bus.mem_ack) begin
            r_beat <= r_beat + OFF_W'(1);
            if (w_last) begin
              r_state <= S_REFILL;
            end
          end
        end
        S_REFILL: begin
          if (bus.mem_ack) begin
            r_beat <= r_beat + OFF_W'(1);
            if (w_last) begin
              r_valid[r_idx] <= 1'b1;
              r_dirty[r_idx] <= 1'b0;
              r_state        <= S_COMPARE;
            end
          end
        end
        default: r_state <= S_COMPARE;
      endcase
    end
  end

  // Tag store needs no reset; valid bits qualify every lookup.
  always_ff @(posedge clk) begin
    if (w_fill_done) begin
      r_tag_arr[r_idx] <= r_req_tag;
    end
  end
endmodule

// File: tb/tb_dcache_miss_controller.sv
// Directed bench for dcache_miss_controller: expected memory beats are queued when
// a request is issued and checked as the controller presents them.
module tb_dcache_miss_controller;
  logic clk;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  typedef struct {
    logic        we;
    logic [31:0] addr;
  } beat_t;

  beat_t exp_q[$];

  dcache_miss_controller_if #(.NUM_LINES(256), .BLOCK_WORDS(4)) bus ();

  dcache_miss_controller #(.NUM_LINES(256), .BLOCK_WORDS(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp_v);
    end
  endtask

  task automatic access(input logic [31:0] addr, input logic wr);
    bus.req_valid = 1'b1;
    bus.req_write = wr;
    bus.req_addr  = addr;
    #1;
  endtask

  task automatic push_line(input logic we, input logic [31:0] base);
    beat_t b;
    for (int i = 0; i < 4; i++) begin
      b.we   = we;
      b.addr = base + 32'(4 * i);
      exp_q.push_back(b);
    end
  endtask

  // Answers n beats, comparing each presented beat against the scoreboard head.
  task automatic serve(input int n, input bit refill, input int stall_beat,
                       input int stall_cycles, input int idx);
    beat_t e;
    for (int b = 0; b < n; b++) begin
      int w = 0;
      while (bus.mem_req !== 1'b1 && w < 20) begin
        tick();
        w++;
      end
      if (bus.mem_req !== 1'b1) begin
        chk("mem_req_timeout", 32'(bus.mem_req), 32'd1);
        return;
      end
      if (exp_q.size() == 0) begin
        chk("sb_unexpected_beat", bus.mem_addr, 32'hDEAD_BEEF);
        return;
      end
      e = exp_q.pop_front();
      chk("beat_addr", bus.mem_addr, e.addr);
      chk("beat_we", 32'(bus.mem_we), 32'(e.we));
      if (b == stall_beat) begin
        for (int s = 0; s < stall_cycles; s++) begin
          tick();
          chk("stall_mem_req", 32'(bus.mem_req), 32'd1);
          chk("stall_mem_addr", bus.mem_addr, e.addr);
          chk("stall_mem_we", 32'(bus.mem_we), 32'(e.we));
          chk("stall_hit", 32'(bus.hit), 32'd0);
        end
      end
      bus.mem_ack = 1'b1;
      #1;
      chk("ack_da_we", 32'(bus.da_we), 32'(refill));
      if (refill) begin
        chk("ack_da_src", 32'(bus.da_src), 32'd1);
        chk("ack_da_index", 32'(bus.da_index), 32'(idx * 4 + b));
      end
      tick();
      bus.mem_ack = 1'b0;
    end
  endtask

  initial begin
    rst           = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_addr  = 32'h0;
    bus.mem_ack   = 1'b0;
    tick();
    tick();
    chk("rst_hit", 32'(bus.hit), 32'd0);
    chk("rst_mem_req", 32'(bus.mem_req), 32'd0);
    chk("rst_da_we", 32'(bus.da_we), 32'd0);
    chk("rst_mem_addr", bus.mem_addr, 32'h0);
    chk("rst_da_index", 32'(bus.da_index), 32'h0);
    chk("rst_hit_count", bus.hit_count, 32'd0);
    chk("rst_miss_count", bus.miss_count, 32'd0);
    rst = 1'b0;
    tick();

    // Cold miss on LW 0x1000, refill of line 0 with tag 1
    access(32'h0000_1000, 1'b0);
    chk("t1_miss_hit", 32'(bus.hit), 32'd0);
    push_line(1'b0, 32'h0000_1000);
    tick();
    serve(4, 1'b1, -1, 0, 0);
    chk("t1_hit_after_fill", 32'(bus.hit), 32'd1);
    chk("t1_miss_count", bus.miss_count, 32'd1);
    tick();

    // Same-line load hits immediately
    access(32'h0000_1008, 1'b0);
    chk("t2_hit", 32'(bus.hit), 32'd1);
    chk("t2_mem_req", 32'(bus.mem_req), 32'd0);
    tick();
    bus.req_valid = 1'b0;
    #1;
    chk("t2_hit_count", bus.hit_count, 32'd2);
    chk("idle_hit", 32'(bus.hit), 32'd0);

    // Store hit writes CPU data and dirties line 0
    access(32'h0000_1004, 1'b1);
    chk("t3_hit", 32'(bus.hit), 32'd1);
    chk("t3_da_we", 32'(bus.da_we), 32'd1);
    chk("t3_da_src", 32'(bus.da_src), 32'd0);
    chk("t3_da_index", 32'(bus.da_index), 32'h001);
    tick();
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;

    // Stray mem_ack while idle is ignored
    bus.mem_ack = 1'b1;
    #1;
    chk("stray_ack_da_we", 32'(bus.da_we), 32'd0);
    tick();
    bus.mem_ack = 1'b0;
    #1;
    chk("stray_ack_mem_req", 32'(bus.mem_req), 32'd0);
    chk("stray_ack_hit_count", bus.hit_count, 32'd3);
    chk("stray_ack_miss_count", bus.miss_count, 32'd1);

    // Conflict miss on dirty line: writeback then refill, with a 10-cycle stall
    access(32'h0000_2000, 1'b0);
    chk("t4_miss_hit", 32'(bus.hit), 32'd0);
    push_line(1'b1, 32'h0000_1000);
    push_line(1'b0, 32'h0000_2000);
    tick();
    serve(4, 1'b0, -1, 0, 0);
    serve(4, 1'b1, 1, 10, 0);
    chk("t4_hit_after_fill", 32'(bus.hit), 32'd1);
    chk("t4_miss_count", bus.miss_count, 32'd2);
    tick();
    bus.req_valid = 1'b0;
    #1;
    chk("t4_hit_count", bus.hit_count, 32'd4);

    // Clean conflict miss goes straight to refill; reset after two beats aborts it
    access(32'h0000_3000, 1'b0);
    chk("t6_miss_hit", 32'(bus.hit), 32'd0);
    push_line(1'b0, 32'h0000_3000);
    tick();
    serve(2, 1'b1, -1, 0, 0);
    chk("t6_pre_rst_mem_req", 32'(bus.mem_req), 32'd1);
    rst = 1'b1;
    #1;
    chk("t6_rst_mem_req", 32'(bus.mem_req), 32'd0);
    chk("t6_rst_mem_addr", bus.mem_addr, 32'h0);
    chk("t6_rst_miss_count", bus.miss_count, 32'd0);
    chk("t6_rst_hit_count", bus.hit_count, 32'd0);
    exp_q.delete();
    tick();
    rst = 1'b0;

    // Cache is empty again: previously resident line misses and refills from beat 0
    access(32'h0000_2000, 1'b0);
    chk("t6_reissue_hit", 32'(bus.hit), 32'd0);
    push_line(1'b0, 32'h0000_2000);
    tick();
    serve(4, 1'b1, -1, 0, 0);
    chk("t6_hit_after_fill", 32'(bus.hit), 32'd1);
    chk("t6_miss_count", bus.miss_count, 32'd1);
    tick();
    bus.req_valid = 1'b0;
    #1;
    chk("t6_hit_count", bus.hit_count, 32'd1);
    chk("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
